// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising serial PRBS checker with lock tracking and saturating error count
module prbs_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter int               LOCK_CNT = 8,
    parameter int               LOSS_CNT = 4,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic             sync_loss,
    output logic [CNT_W-1:0] err_count
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] r, r_n;
    logic [FW-1:0]    fill, fill_n;
    logic [MW-1:0]    match, match_n;
    logic [LW-1:0]    miss, miss_n;
    logic             locked_n, err_n, sync_loss_n;
    logic [CNT_W-1:0] err_count_n;
    logic             expected;
    logic             mismatch;
    logic             count_inc;

    // Prediction from the current history; r[0] holds the newest bit
    assign expected = ^(r & TAPS);
    assign mismatch = (in_bit != expected);

    // Register all state and registered outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEED;
            r         <= '0;
            fill      <= '0;
            match     <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            sync_loss <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            r         <= r_n;
            fill      <= fill_n;
            match     <= match_n;
            miss      <= miss_n;
            locked    <= locked_n;
            err       <= err_n;
            sync_loss <= sync_loss_n;
            err_count <= err_count_n;
        end
    end

    // Next-state logic: seed the history, verify it, then track errors while locked
    always_comb begin
        state_n     = state;
        r_n         = r;
        fill_n      = fill;
        match_n     = match;
        miss_n      = miss;
        locked_n    = locked;
        err_n       = 1'b0;
        sync_loss_n = 1'b0;
        count_inc   = 1'b0;

        if (in_valid) begin
            case (state)
                SEED: begin
                    r_n = {r[WIDTH-2:0], in_bit};
                    if (fill == FW'(WIDTH - 1)) begin
                        fill_n = '0;
                        // An all-zero history is the LFSR lockup value: refill instead
                        if (r_n != '0) begin
                            state_n = CHECK;
                            match_n = '0;
                        end
                    end else begin
                        fill_n = fill + 1'b1;
                    end
                end
                CHECK: begin
                    // Received bits are shifted in so the checker follows the stream
                    r_n = {r[WIDTH-2:0], in_bit};
                    if (!mismatch) begin
                        if (match == MW'(LOCK_CNT - 1)) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            match_n  = '0;
                            miss_n   = '0;
                        end else begin
                            match_n = match + 1'b1;
                        end
                    end else begin
                        state_n = SEED;
                        fill_n  = '0;
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Predicted bits are shifted in so one flipped bit is counted once
                    r_n = {r[WIDTH-2:0], expected};
                    if (mismatch) begin
                        err_n     = 1'b1;
                        count_inc = 1'b1;
                        if (miss == LW'(LOSS_CNT - 1)) begin
                            state_n     = SEED;
                            locked_n    = 1'b0;
                            sync_loss_n = 1'b1;
                            fill_n      = '0;
                            miss_n      = '0;
                        end else begin
                            miss_n = miss + 1'b1;
                        end
                    end else begin
                        miss_n = '0;
                    end
                end
                default: begin
                    state_n = SEED;
                    fill_n  = '0;
                    match_n = '0;
                    miss_n  = '0;
                end
            endcase
        end

        // Clear takes priority over a same-cycle increment; count saturates
        if (clr_cnt) begin
            err_count_n = '0;
        end else if (count_inc && (err_count != {CNT_W{1'b1}})) begin
            err_count_n = err_count + 1'b1;
        end else begin
            err_count_n = err_count;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed self-checking bench for prbs_checker
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        clr_cnt;
    logic        locked, err, sync_loss;
    logic [15:0] err_count;
    logic        locked4, err4, sync_loss4;
    logic [3:0]  err_count4;

    logic [7:0]  s;
    int          vectors    = 0;
    int          miscompares = 0;

    prbs_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err       (err),
        .sync_loss (sync_loss),
        .err_count (err_count)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked4),
        .err       (err4),
        .sync_loss (sync_loss4),
        .err_count (err_count4)
    );

    always #5 clk = ~clk;

    // Reference generator: s <= {s[6:0], fb}, emitted bit = fb
    task automatic gen(output logic b);
        logic fb;
        fb = ^(s & 8'hB8);
        s  = {s[6:0], fb};
        b  = fb;
    endtask

    // Apply one cycle of input; outputs are sampled 1 time unit after the edge
    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        clr_cnt = 1'b0;
        step(1'b0, 1'b0);
        rst = 1'b0;
        s   = 8'h01;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        rst     = 1'b0;
        clr_cnt = 1'b0;
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b expected 0", err); end
        vectors++;
        if (sync_loss !== 1'b0) begin miscompares++; $display("FAIL reset_sync_loss: got %0b expected 0", sync_loss); end
        vectors++;
        if (err_count !== 16'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_clean_lock();
        logic b;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            gen(b);
            step(1'b1, b);
            vectors++;
            if (locked !== (i >= 15)) begin miscompares++; $display("FAIL clean_locked bit %0d: got %0b expected %0b", i, locked, (i >= 15)); end
            vectors++;
            if (err !== 1'b0) begin miscompares++; $display("FAIL clean_err bit %0d: got %0b expected 0", i, err); end
        end
        vectors++;
        if (err_count !== 16'd0) begin miscompares++; $display("FAIL clean_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_single_error();
        logic b;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            gen(b);
            if (i == 100) b = ~b;
            step(1'b1, b);
            vectors++;
            if (err !== (i == 100)) begin miscompares++; $display("FAIL single_err bit %0d: got %0b expected %0b", i, err, (i == 100)); end
            vectors++;
            if (locked !== (i >= 15)) begin miscompares++; $display("FAIL single_locked bit %0d: got %0b expected %0b", i, locked, (i >= 15)); end
        end
        vectors++;
        if (err_count !== 16'd1) begin miscompares++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
    endtask

    task automatic test_loss_relock();
        logic b;
        logic exp_lock;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            gen(b);
            if (i >= 150 && i <= 153) b = ~b;
            step(1'b1, b);
            exp_lock = ((i >= 15) && (i < 153)) || (i >= 169);
            vectors++;
            if (locked !== exp_lock) begin miscompares++; $display("FAIL loss_locked bit %0d: got %0b expected %0b", i, locked, exp_lock); end
            vectors++;
            if (err !== (i >= 150 && i <= 153)) begin miscompares++; $display("FAIL loss_err bit %0d: got %0b expected %0b", i, err, (i >= 150 && i <= 153)); end
            vectors++;
            if (sync_loss !== (i == 153)) begin miscompares++; $display("FAIL loss_sync_loss bit %0d: got %0b expected %0b", i, sync_loss, (i == 153)); end
        end
        vectors++;
        if (err_count !== 16'd4) begin miscompares++; $display("FAIL loss_err_count: got %0d expected 4", err_count); end
    endtask

    task automatic test_lockup_gaps();
        logic b;
        int   vc;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0);
            vectors++;
            if (locked !== 1'b0) begin miscompares++; $display("FAIL lockup_locked bit %0d: got %0b expected 0", i, locked); end
        end
        do_reset();
        vc = 0;
        for (int k = 0; k < 64; k++) begin
            if (k % 2 == 0) begin
                gen(b);
                step(1'b1, b);
                vc++;
            end else begin
                step(1'b0, 1'($urandom));
            end
            vectors++;
            if (locked !== (vc >= 16)) begin miscompares++; $display("FAIL gaps_locked clock %0d: got %0b expected %0b", k, locked, (vc >= 16)); end
        end
        vectors++;
        if (err_count !== 16'd0) begin miscompares++; $display("FAIL gaps_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_saturation_clear();
        logic b;
        int   nerr;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            gen(b);
            step(1'b1, b);
        end
        nerr = 0;
        for (int i = 0; i < 200; i++) begin
            gen(b);
            if (i % 10 == 0) begin
                b = ~b;
                nerr++;
            end
            step(1'b1, b);
            vectors++;
            if (err_count4 !== 4'((nerr > 15) ? 15 : nerr)) begin miscompares++; $display("FAIL sat_count4 bit %0d: got %0d expected %0d", i, err_count4, (nerr > 15) ? 15 : nerr); end
        end
        vectors++;
        if (err_count !== 16'd20) begin miscompares++; $display("FAIL sat_count16: got %0d expected 20", err_count); end
        vectors++;
        if (locked4 !== 1'b1) begin miscompares++; $display("FAIL sat_locked: got %0b expected 1", locked4); end
        gen(b);
        clr_cnt = 1'b1;
        step(1'b1, ~b);
        clr_cnt = 1'b0;
        vectors++;
        if (err_count4 !== 4'd0) begin miscompares++; $display("FAIL clr_count4: got %0d expected 0", err_count4); end
        vectors++;
        if (err_count !== 16'd0) begin miscompares++; $display("FAIL clr_count16: got %0d expected 0", err_count); end
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL clr_err: got %0b expected 1", err); end
        gen(b);
        step(1'b1, b);
        vectors++;
        if (err_count !== 16'd0) begin miscompares++; $display("FAIL clr_hold: got %0d expected 0", err_count); end
    endtask

    task automatic test_reset_mid_lock();
        logic b;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            gen(b);
            if (i == 20 || i == 30 || i == 40) b = ~b;
            step(1'b1, b);
        end
        vectors++;
        if (err_count !== 16'd3) begin miscompares++; $display("FAIL midrst_pre_count: got %0d expected 3", err_count); end
        gen(b);
        rst = 1'b1;
        step(1'b1, ~b);
        rst = 1'b0;
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL midrst_locked: got %0b expected 0", locked); end
        vectors++;
        if (err_count !== 16'd0) begin miscompares++; $display("FAIL midrst_count: got %0d expected 0", err_count); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %0b expected 0", err); end
        for (int j = 0; j < 20; j++) begin
            gen(b);
            step(1'b1, b);
            vectors++;
            if (locked !== (j >= 15)) begin miscompares++; $display("FAIL midrst_relock bit %0d: got %0b expected %0b", j, locked, (j >= 15)); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clr_cnt  = 1'b0;
        s        = 8'h01;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_relock();
        test_lockup_gaps();
        test_saturation_clear();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS checker. It receives the one-bit-per-cycle stream produced by the team's Fibonacci LFSR generator.
- It self-synchronises to the stream, declares lock, then counts bit errors against the locally predicted sequence.
- It sits at the receive end of LFSR link/BIST loopback paths and reports lock, per-bit error pulses and a saturating error count.

Parameters:
- WIDTH, 8, LFSR length in bits (>=3).
- TAPS, 8'hB8, feedback mask, WIDTH bits; bit k set = received bit from k+1 valid cycles ago feeds the prediction. Default = x^8+x^6+x^5+x^4+1.
- LOCK_CNT, 8, consecutive matching bits needed in CHECK to declare lock (>=1).
- LOSS_CNT, 4, consecutive mismatches in LOCKED that drop lock (>=1).
- CNT_W, 16, err_count width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is a valid stream bit this cycle.
- in_bit  in  1  received stream bit.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  registered lock status.
- err  out  1  one-cycle pulse: previous valid bit mismatched while LOCKED.
- sync_loss  out  1  one-cycle pulse on the LOCKED->SEED transition.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=SEED, history register r=0, fill/match/miss counters=0, locked=0, err=0, sync_loss=0, err_count=0. rst asserted mid-operation gives the same result on the next edge, regardless of other inputs.
- in_valid=0 cycles: no state, counter or register change. err and sync_loss deassert, since pulses last exactly one clock.
- Prediction:
  - r[0] is the most recent bit; expected = ^(r & TAPS).
  - Generator convention: s <= {s[WIDTH-2:0], fb}, emitted bit = fb = ^(s & TAPS).
- State SEED, per valid bit:
  - r <= {r[WIDTH-2:0], in_bit}; fill++.
  - On the WIDTH-th bit, fill resets to 0. If the new r is nonzero, go to CHECK with match=0. If r is all zero (lockup value), stay in SEED and refill.
- State CHECK, per valid bit:
  - r <= {r[WIDTH-2:0], in_bit}, shifting in the received bit (self-sync).
  - If in_bit==expected: match++. On reaching LOCK_CNT, go to LOCKED and set locked=1 on that same edge.
  - If in_bit!=expected: go to SEED with fill=0, match=0.
  - No errors are counted in CHECK.
- State LOCKED, per valid bit:
  - r <= {r[WIDTH-2:0], expected}, shifting in the predicted bit, so one flipped bit counts exactly once.
  - Mismatch: err=1 next cycle, err_count+1 (saturating at 2^CNT_W-1), miss++.
  - Match: miss=0.
  - When miss reaches LOSS_CNT: go to SEED, locked=0, sync_loss=1 for one cycle, fill=miss=0. The LOSS_CNT-th mismatch is still counted and pulses err.
- Latency: with a clean stream, locked rises on the edge sampling valid bit number WIDTH+LOCK_CNT (16 with defaults). err and sync_loss are registered, one cycle after the sampled bit.
- clr_cnt: err_count <= 0 and has priority over a simultaneous increment. It does not affect state, locked or err.
- err_count is not cleared by loss of lock, only by rst or clr_cnt.

Test Plan:
- Clean lock: generator seed 8'h01, defaults, 300 consecutive valid bits -> locked=1 after 16th bit edge, stays 1; err never pulses; err_count=0.
- Single error: same stream, flip bit index 100 -> exactly one err pulse; err_count=1; locked stays 1; following bits match.
- Loss and relock: 4 consecutive flipped bits at index 150..153 -> 4 err pulses; err_count=4; locked=0 and sync_loss pulses on the 153rd bit edge; locked returns after 16 further clean bits; err_count stays 4.
- Lockup and gaps: 100 bits all zero -> locked never asserts, state cycles SEED. Clean stream with in_valid toggled 1/0 every cycle -> locked after 16 valid bits (32 clocks); err_count=0.
- Saturation/clear: CNT_W=4, locked, 20 isolated single-bit errors spaced 10 bits apart -> err_count=15. clr_cnt asserted on same cycle as an error -> err_count=0.
- Reset mid-lock: rst for one cycle while LOCKED with err_count=3 -> next edge locked=0, err_count=0, err=0; relock after 16 valid bits.
